// File: rtl/uart_alu_sequencer.sv
// Frame sequencer: pops A, B, opcode from RX FIFO, runs the ALU, pushes one result byte to TX FIFO.
// Latency: opcode pop edge T, result registered T+1, TX push at edge T+2; 5-cycle minimum frame period.
// Backpressure: holds in pop states while RX empty, holds in PUT while TX full; optional ALU_SEQ_TIMEOUT_EN drops stale partial frames.
module uart_alu_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int OP_WIDTH   = 6,
    parameter int TIMEOUT    = 1000
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_rx_empty,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    output logic                  o_rx_read,
    input  logic                  i_tx_full,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_write,
    output logic [DATA_WIDTH-1:0] o_alu_a,
    output logic [DATA_WIDTH-1:0] o_alu_b,
    output logic [OP_WIDTH-1:0]   o_alu_op,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    output logic                  o_busy,
    output logic                  o_timeout
);

    typedef enum logic [2:0] {
        ST_GET_A,
        ST_GET_B,
        ST_GET_OP,
        ST_EXEC,
        ST_PUT
    } state_t;

    state_t state;
    logic   pop_state;

    assign pop_state  = (state == ST_GET_A) || (state == ST_GET_B) || (state == ST_GET_OP);
    // Strobes are gated by reset so no FIFO side effect happens while it is held.
    assign o_rx_read  = i_reset && pop_state && !i_rx_empty;
    assign o_tx_write = i_reset && (state == ST_PUT) && !i_tx_full;
    assign o_busy     = (state != ST_GET_A);

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] idle_cnt;
    logic             wait_state;

    assign wait_state = (state == ST_GET_B) || (state == ST_GET_OP);
`else
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state     <= ST_GET_A;
            o_alu_a   <= '0;
            o_alu_b   <= '0;
            o_alu_op  <= '0;
            o_tx_data <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
            idle_cnt  <= '0;
            o_timeout <= 1'b0;
`endif
        end else begin
            case (state)
                ST_GET_A: begin
                    if (o_rx_read) begin
                        o_alu_a <= i_rx_data;
                        state   <= ST_GET_B;
                    end
                end
                ST_GET_B: begin
                    if (o_rx_read) begin
                        o_alu_b <= i_rx_data;
                        state   <= ST_GET_OP;
                    end
                end
                ST_GET_OP: begin
                    if (o_rx_read) begin
                        o_alu_op <= i_rx_data[OP_WIDTH-1:0];
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    o_tx_data <= i_alu_result;
                    state     <= ST_PUT;
                end
                ST_PUT: begin
                    if (o_tx_write) begin
                        state <= ST_GET_A;
                    end
                end
                default: state <= ST_GET_A;
            endcase
`ifdef ALU_SEQ_TIMEOUT_EN
            // A pop on the expiry cycle takes the first branch, so the frame advances instead.
            o_timeout <= 1'b0;
            if (o_rx_read || !wait_state) begin
                idle_cnt <= '0;
            end else if (idle_cnt == CNT_W'(TIMEOUT - 1)) begin
                idle_cnt  <= '0;
                state     <= ST_GET_A;
                o_timeout <= 1'b1;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Scoreboard bench for uart_alu_sequencer: FIFO models around the DUT, a small ALU model,
// and a negedge monitor that matches every TX push against queued expectations.
module tb_uart_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_empty = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_read;
    logic       tx_full = 1'b0;
    logic [7:0] tx_data;
    logic       tx_write;
    logic [7:0] alu_a, alu_b, alu_result;
    logic [5:0] alu_op;
    logic       busy, tmo;

    always #5 clk = ~clk;

    uart_alu_sequencer #(.DATA_WIDTH(8), .OP_WIDTH(6), .TIMEOUT(16)) dut (
        .i_clock(clk), .i_reset(rst_n),
        .i_rx_empty(rx_empty), .i_rx_data(rx_data), .o_rx_read(rx_read),
        .i_tx_full(tx_full), .o_tx_data(tx_data), .o_tx_write(tx_write),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
        .i_alu_result(alu_result), .o_busy(busy), .o_timeout(tmo)
    );

    always_comb begin
        alu_result = 8'h00;
        case (alu_op)
            6'h20: alu_result = alu_a + alu_b;
            6'h22: alu_result = alu_a - alu_b;
            6'h24: alu_result = alu_a & alu_b;
            6'h25: alu_result = alu_a | alu_b;
            6'h26: alu_result = alu_a ^ alu_b;
            default: alu_result = 8'h00;
        endcase
    end

    typedef struct {
        logic [7:0] data;
        int         gap;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [7:0] rx_q[$];
    int         push_edges[$];
    int         vectors = 0;
    int         errors = 0;
    int         cyc = 0;
    int         pop_cnt = 0;
    int         last_pop_edge = 0;
    logic       pop_s = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // RX FIFO model: first-word-fall-through, pop decided from the strobe sampled before the edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (pop_s) begin
            if (rx_q.size() > 0) void'(rx_q.pop_front());
            pop_cnt++;
        end
        rx_empty = (rx_q.size() == 0);
        rx_data  = rx_empty ? 8'h00 : rx_q[0];
    end

    // Monitor: edge numbers refer to the posedge that follows this negedge.
    always @(negedge clk) begin
        pop_s = rx_read;
        if (rx_read) last_pop_edge = cyc + 1;
        if (tx_write) begin
            push_edges.push_back(cyc + 1);
            check("no_pop_on_push", {31'd0, rx_read}, 32'd0);
            if (sb.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_push: got data 0x%0h expected no push", tx_data);
            end else begin
                e = sb.pop_front();
                check("tx_data", {24'd0, tx_data}, {24'd0, e.data});
                check("push_latency", cyc + 1 - last_pop_edge, e.gap);
            end
        end
    end

    task automatic send(input logic [7:0] b);
        rx_q.push_back(b);
    endtask

    task automatic expect_push(input logic [7:0] d, input int gap);
        sb.push_back('{data: d, gap: gap});
    endtask

    task automatic wait_pops(input int n);
        int k = 0;
        while (pop_cnt < n && k < 300) begin
            @(posedge clk); #2;
            k++;
        end
        if (pop_cnt < n) begin
            vectors++;
            errors++;
            $display("FAIL wait_pops: got %0d pops expected %0d", pop_cnt, n);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((sb.size() != 0 || busy || rx_q.size() != 0) && k < 300) begin
            @(posedge clk); #2;
            k++;
        end
        if (sb.size() != 0 || busy) begin
            vectors++;
            errors++;
            $display("FAIL wait_idle: got %0d pending pushes, busy=%0d expected 0, 0", sb.size(), busy);
        end
    endtask

    initial begin
        int p0;
        int n0;
        int k_found;
        logic seen;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", tmo, 0);
        check("rst_strobes", {rx_read, tx_write}, 0);
        #1 rst_n = 1'b1;

        // Single frame: 5 + 3 via op 0x20
        send(8'h05); send(8'h03); send(8'h20);
        expect_push(8'h08, 2);
        wait_idle();
        check("single_a", alu_a, 8'h05);
        check("single_b", alu_b, 8'h03);
        check("single_op", alu_op, 6'h20);

        // Back-to-back frames, second wraps to 0x00
        p0 = pop_cnt;
        n0 = push_edges.size();
        send(8'h05); send(8'h03); send(8'h20);
        send(8'hFF); send(8'h01); send(8'h20);
        expect_push(8'h08, 2);
        expect_push(8'h00, 2);
        wait_pops(p0 + 6);
        wait_idle();
        check("b2b_pops", pop_cnt - p0, 6);
        check("b2b_push_count", push_edges.size() - n0, 2);
        if (push_edges.size() - n0 == 2)
            check("b2b_spacing", push_edges[n0 + 1] - push_edges[n0], 5);

        // Opcode bits above the low six are dropped: 0xE4 -> AND
        send(8'h3C); send(8'h0F); send(8'hE4);
        expect_push(8'h0C, 2);
        wait_idle();
        check("op_mask", alu_op, 6'h24);

        // TX backpressure for 10 cycles after EXEC, next frame already waiting in RX
        tx_full = 1'b1;
        p0 = pop_cnt;
        send(8'h12); send(8'h34); send(8'h20);
        expect_push(8'h46, 12);
        wait_pops(p0 + 3);
        send(8'h09); send(8'h04); send(8'h22);
        expect_push(8'h05, 2);
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_no_write", tx_write, 0);
            check("bp_no_read", rx_read, 0);
            check("bp_tx_stable", tx_data, 8'h46);
        end
        @(posedge clk); #2;
        tx_full = 1'b0;
        wait_idle();

        // RX bytes spaced 7 cycles apart
        p0 = pop_cnt;
        send(8'h81);
        wait_pops(p0 + 1);
        repeat (6) @(posedge clk);
        check("gap_busy_after_a", busy, 1);
        send(8'h7F);
        wait_pops(p0 + 2);
        repeat (6) @(posedge clk);
        check("gap_busy_after_b", busy, 1);
        check("gap_pops_ab", pop_cnt - p0, 2);
        send(8'h25);
        expect_push(8'hFF, 2);
        wait_idle();
        check("gap_pops", pop_cnt - p0, 3);

        // Partial frame: only A and B arrive
        p0 = pop_cnt;
        send(8'h05); send(8'h03);
        wait_pops(p0 + 2);
`ifdef ALU_SEQ_TIMEOUT_EN
        k_found = -1;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            if (tmo) begin
                k_found = k;
                break;
            end
        end
        check("timeout_delay", k_found, 16);
        check("timeout_idle", busy, 0);
        check("timeout_keep_a", alu_a, 8'h05);
        check("timeout_keep_b", alu_b, 8'h03);
        @(negedge clk);
        check("timeout_pulse_width", tmo, 0);
        send(8'h07); send(8'h02); send(8'h26);
        expect_push(8'h05, 2);
        wait_idle();
`else
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (tmo) seen = 1'b1;
        end
        check("no_timeout", seen, 0);
        check("waiting_busy", busy, 1);
        check("waiting_op_kept", alu_op, 6'h25);
        send(8'h20);
        expect_push(8'h08, 2);
        wait_idle();
`endif

        // Reset after the B pop
        p0 = pop_cnt;
        send(8'h05); send(8'h03);
        wait_pops(p0 + 2);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_a", alu_a, 0);
        check("mid_rst_b", alu_b, 0);
        check("mid_rst_op", alu_op, 0);
        check("mid_rst_tx_data", tx_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_strobes", {rx_read, tx_write, tmo}, 0);
        send(8'h0C);
        @(posedge clk); #2;
        check("rst_gates_read", {rx_empty, rx_read}, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        send(8'h0A); send(8'h22);
        expect_push(8'h02, 2);
        wait_idle();
        check("post_rst_a", alu_a, 8'h0C);
        check("post_rst_b", alu_b, 8'h0A);
        check("post_rst_op", alu_op, 6'h22);

        repeat (3) @(posedge clk);
        check("sb_drained", sb.size(), 0);
        check("rx_drained", rx_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
